// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stall controller.
//   - state encoding of the controller FSM
//   - default timeout (cycles spent waiting for mem_ack before flagging err)
package dmem_pkg;

   typedef logic [1:0] dmem_state_t;

   localparam dmem_state_t ST_IDLE = 2'b00;
   localparam dmem_state_t ST_BUSY = 2'b01;
   localparam dmem_state_t ST_DONE = 2'b10;
   localparam dmem_state_t ST_ERR  = 2'b11;

   localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/dmem_reg.sv
// Generic holding register with write enable and synchronous reset to zero.
//   clk  : clock
//   rst  : synchronous active-high reset, clears q
//   en   : load d into q at the rising edge
//   d    : data in
//   q    : registered data out
module dmem_reg #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/dmem_stall_ctrl_timeout_cnt.sv
// Saturating up-counter used to bound the wait for mem_ack.
//   clk : clock
//   rst : synchronous active-high reset, clears the count
//   clr : clear the count (takes priority over en)
//   en  : increment by one; holds at all-ones instead of wrapping
//   hit : count == TIMEOUT-1
module dmem_timeout_cnt
   import dmem_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic hit
);

   // One spare bit above what TIMEOUT-1 needs so saturation never aliases hit.
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_reg <= '0;
      end else if (en && (cnt_reg != CNT_MAX)) begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign hit = (cnt_reg == HIT_VAL);

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Memory-stage controller between the EX/MEM latch and a multi-cycle data
// memory with a req/ack handshake. Stalls the pipeline while an access is
// outstanding, returns load data with a one-cycle done pulse and raises a
// sticky err on unaligned, conflicting or timed-out accesses.
//   clk, rst          : clock, synchronous active-high reset
//   rd_req, wr_req    : load / store request from EX/MEM
//   addr, wrdata      : byte address and store data from EX/MEM
//   rdata             : load data, valid with done, held until next load
//   stall             : combinational pipeline freeze
//   done              : one-cycle completion pulse
//   err               : sticky error, cleared only by rst
//   mem_req, mem_we   : registered backing-memory request / write select
//   mem_addr          : registered word address (bit 0 forced to 0)
//   mem_wdata         : registered store data
//   mem_ack, mem_rdata: backing-memory completion and read data
module dmem_stall_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wrdata,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic              done,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   dmem_state_t state_reg;
   dmem_state_t state_next;
   logic        mem_req_reg;
   logic        req_any;
   logic        req_valid;
   logic        accept;
   logic        ack_busy;
   logic        in_busy;
   logic        timeout_hit;

   // A request is legal only when exactly one of rd/wr is set and the
   // address is halfword aligned.
   assign req_any   = rd_req | wr_req;
   assign req_valid = (rd_req ^ wr_req) & ~addr[0];
   assign accept    = (state_reg == ST_IDLE) & req_valid;
   assign in_busy   = (state_reg == ST_BUSY);
   // mem_ack is only meaningful while our request is on the bus.
   assign ack_busy  = in_busy & mem_req_reg & mem_ack;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; an ack in the timeout cycle still completes the access.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req_any) begin
               state_next = req_valid ? ST_BUSY : ST_ERR;
            end
         end
         ST_BUSY: begin
            if (ack_busy) begin
               state_next = ST_DONE;
            end else if (timeout_hit) begin
               state_next = ST_ERR;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_ERR;
      endcase
   end

   // Outputs
   always_comb begin
      stall = accept | in_busy;
      done  = (state_reg == ST_DONE);
      err   = (state_reg == ST_ERR);
   end

   // mem_req is high exactly while the registered state is BUSY, so it is
   // simply the next state decoded one cycle early.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req_reg <= 1'b0;
      end else begin
         mem_req_reg <= (state_next == ST_BUSY);
      end
   end

   assign mem_req = mem_req_reg;

   dmem_reg #(.W(1)) u_we_reg (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .d   (wr_req),
      .q   (mem_we)
   );

   dmem_reg #(.W(ADDR_W)) u_addr_reg (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .d   ({addr[ADDR_W-1:1], 1'b0}),
      .q   (mem_addr)
   );

   dmem_reg #(.W(DATA_W)) u_wdata_reg (
      .clk (clk),
      .rst (rst),
      .en  (accept),
      .d   (wrdata),
      .q   (mem_wdata)
   );

   // Stores leave rdata untouched.
   dmem_reg #(.W(DATA_W)) u_rdata_reg (
      .clk (clk),
      .rst (rst),
      .en  (ack_busy & ~mem_we),
      .d   (mem_rdata),
      .q   (rdata)
   );

   dmem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout_cnt (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .en  (in_busy),
      .hit (timeout_hit)
   );

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
module tb_dmem_stall_ctrl;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_req, wr_req;
   logic [AW-1:0] addr;
   logic [DW-1:0] wrdata;
   logic [DW-1:0] rdata;
   logic          stall, done, err;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] exp_q[$];

   always #5 clk = ~clk;

   dmem_stall_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
      .wrdata(wrdata), .rdata(rdata), .stall(stall), .done(done), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: actual=still running required=finished");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drives one access and acts as the backing memory: ack is returned in
   // mem_req cycle number ack_dly (0 = first), never if ack_dly < 0.
   // Observations are returned; the calling test does the comparing.
   task automatic run_access(input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd, input int ack_dly,
                             input logic [DW-1:0] rd_val,
                             output int stall_cnt, output int req_cnt,
                             output int first_req, output logic got_done,
                             output logic c0_busy, output logic [AW-1:0] ma,
                             output logic mwe, output logic [DW-1:0] mwd,
                             output logic [DW-1:0] rdat);
      stall_cnt = 0; req_cnt = 0; first_req = -1; got_done = 1'b0;
      ma = '0; mwe = 1'b0; mwd = '0; rdat = '0;
      @(negedge clk);
      rd_req = ~wr; wr_req = wr; addr = a; wrdata = wd;
      #1;
      c0_busy = mem_req | done;
      if (stall) stall_cnt++;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0;
         if (mem_req) begin
            if (first_req < 0) begin
               first_req = cyc; ma = mem_addr; mwe = mem_we; mwd = mem_wdata;
            end
            if (req_cnt == ack_dly) begin
               mem_ack = 1'b1; mem_rdata = rd_val;
            end
            req_cnt++;
         end
         #1;
         if (stall) stall_cnt++;
         if (done) begin
            rdat = rdata; got_done = 1'b1;
            break;
         end
         if (err) break;
      end
      $display("access %s addr=%h wdata=%h stalls=%0d req_cycles=%0d done=%0b rdata=%h",
               wr ? "ST" : "LD", a, wd, stall_cnt, req_cnt, got_done, rdat);
   endtask

   task automatic test_reset();
      rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wrdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if ({rdata, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_data: actual=%h/%h/%h required=0", rdata, mem_addr, mem_wdata); end
      checks++; if ({stall, done, err, mem_req, mem_we} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: actual=%b required=00000", {stall, done, err, mem_req, mem_we}); end
      @(negedge clk);
      rst = 1'b0;
      $display("reset released");
   endtask

   task automatic test_load();
      int sc, rc, fr; logic gd, c0b, mwe; logic [AW-1:0] ma; logic [DW-1:0] mwd, rd, ex;
      exp_q.push_back(16'hBEEF);
      run_access(1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF, sc, rc, fr, gd, c0b, ma, mwe, mwd, rd);
      ex = exp_q.pop_front();
      checks++; if (ma !== 16'h0010) begin errors++; $display("FAIL load_addr: actual=%h required=0010", ma); end
      checks++; if (mwe !== 1'b0) begin errors++; $display("FAIL load_we: actual=%b required=0", mwe); end
      checks++; if (sc !== 3) begin errors++; $display("FAIL load_stalls: actual=%0d required=3", sc); end
      checks++; if (gd !== 1'b1) begin errors++; $display("FAIL load_done: actual=%b required=1", gd); end
      checks++; if (rd !== ex) begin errors++; $display("FAIL load_rdata: actual=%h required=%h", rd, ex); end
      @(negedge clk);
      #1;
      checks++; if ({done, rdata} !== {1'b0, 16'hBEEF}) begin errors++; $display("FAIL load_hold: actual=%b/%h required=0/beef", done, rdata); end
   endtask

   task automatic test_store();
      int sc, rc, fr; logic gd, c0b, mwe; logic [AW-1:0] ma; logic [DW-1:0] mwd, rd, ex;
      exp_q.push_back(rdata);
      run_access(1'b1, 16'h0022, 16'h1234, 0, 16'hFFFF, sc, rc, fr, gd, c0b, ma, mwe, mwd, rd);
      ex = exp_q.pop_front();
      checks++; if ({ma, mwe} !== {16'h0022, 1'b1}) begin errors++; $display("FAIL store_addr_we: actual=%h/%b required=0022/1", ma, mwe); end
      checks++; if (mwd !== 16'h1234) begin errors++; $display("FAIL store_wdata: actual=%h required=1234", mwd); end
      checks++; if ({sc, gd} !== {32'd2, 1'b1}) begin errors++; $display("FAIL store_stalls_done: actual=%0d/%b required=2/1", sc, gd); end
      checks++; if (rd !== ex) begin errors++; $display("FAIL store_rdata_kept: actual=%h required=%h", rd, ex); end
   endtask

   task automatic test_back_to_back();
      int sc, rc, fr; logic gd, c0b, mwe; logic [AW-1:0] ma; logic [DW-1:0] mwd, rd, ex;
      exp_q.push_back(16'hA5A5);
      exp_q.push_back(16'h5A5A);
      run_access(1'b0, 16'h0000, 16'h0000, 0, 16'hA5A5, sc, rc, fr, gd, c0b, ma, mwe, mwd, rd);
      ex = exp_q.pop_front();
      checks++; if ({gd, rd} !== {1'b1, ex}) begin errors++; $display("FAIL b2b_first: actual=%b/%h required=1/%h", gd, rd, ex); end
      run_access(1'b0, 16'h0002, 16'h0000, 0, 16'h5A5A, sc, rc, fr, gd, c0b, ma, mwe, mwd, rd);
      ex = exp_q.pop_front();
      checks++; if (c0b !== 1'b0) begin errors++; $display("FAIL b2b_gap: actual=%b required=0", c0b); end
      checks++; if (fr !== 0) begin errors++; $display("FAIL b2b_req_start: actual=%0d required=0", fr); end
      checks++; if ({ma, sc} !== {16'h0002, 32'd2}) begin errors++; $display("FAIL b2b_second_addr: actual=%h/%0d required=0002/2", ma, sc); end
      checks++; if ({gd, rd} !== {1'b1, ex}) begin errors++; $display("FAIL b2b_second: actual=%b/%h required=1/%h", gd, rd, ex); end
   endtask

   task automatic test_timeout();
      int sc, rc, fr; logic gd, c0b, mwe; logic [AW-1:0] ma; logic [DW-1:0] mwd, rd, kept;
      kept = rdata;
      run_access(1'b0, 16'h0040, 16'h0000, -1, 16'hDEAD, sc, rc, fr, gd, c0b, ma, mwe, mwd, rd);
      checks++; if (rc !== TO) begin errors++; $display("FAIL timeout_len: actual=%0d required=%0d", rc, TO); end
      checks++; if ({gd, err, mem_req} !== 3'b010) begin errors++; $display("FAIL timeout_err: actual=%b required=010", {gd, err, mem_req}); end
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      checks++; if ({err, done, mem_req, rdata} !== {3'b100, kept}) begin errors++; $display("FAIL timeout_late_ack: actual=%b/%h required=100/%h", {err, done, mem_req}, rdata, kept); end
      $display("timeout sequence ended err=%0b", err);
   endtask

   task automatic test_unaligned();
      logic bad;
      do_reset();
      @(negedge clk);
      rd_req = 1'b1; addr = 16'h0005;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL unaligned_stall: actual=%b required=0", stall); end
      @(negedge clk);
      rd_req = 1'b0;
      #1;
      checks++; if ({err, mem_req} !== 2'b10) begin errors++; $display("FAIL unaligned_err: actual=%b required=10", {err, mem_req}); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rd_req = i[0]; wr_req = ~i[0]; addr = 16'h0010 + 16'(i * 2);
         #1;
         bad = ({stall, mem_req, err} !== 3'b001);
         checks++; if (bad) begin errors++; $display("FAIL err_sticky_%0d: actual=%b required=001", i, {stall, mem_req, err}); end
      end
      $display("unaligned access flagged, err=%0b", err);
      do_reset();
      @(negedge clk);
      rd_req = 1'b1; wr_req = 1'b1; addr = 16'h0004;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL conflict_stall: actual=%b required=0", stall); end
      @(negedge clk);
      rd_req = 1'b0; wr_req = 1'b0;
      #1;
      checks++; if ({err, mem_req} !== 2'b10) begin errors++; $display("FAIL conflict_err: actual=%b required=10", {err, mem_req}); end
      $display("rd+wr conflict flagged, err=%0b", err);
   endtask

   task automatic test_rst_abort();
      int sc, rc, fr; logic gd, c0b, mwe; logic [AW-1:0] ma; logic [DW-1:0] mwd, rd, ex;
      do_reset();
      @(negedge clk);
      rd_req = 1'b1; addr = 16'h0030;
      @(negedge clk);
      rd_req = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_busy: actual=%b required=1", mem_req); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h0BAD;
      #1;
      checks++; if ({mem_req, stall, err, done} !== 4'b0) begin errors++; $display("FAIL abort_after_rst: actual=%b required=0000", {mem_req, stall, err, done}); end
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      checks++; if ({done, stall, rdata} !== {2'b00, 16'h0000}) begin errors++; $display("FAIL abort_late_ack: actual=%b/%h required=00/0000", {done, stall}, rdata); end
      exp_q.push_back(16'hC0DE);
      run_access(1'b0, 16'h0032, 16'h0000, 2, 16'hC0DE, sc, rc, fr, gd, c0b, ma, mwe, mwd, rd);
      ex = exp_q.pop_front();
      checks++; if ({gd, rd, ma, sc} !== {1'b1, ex, 16'h0032, 32'd4}) begin errors++; $display("FAIL abort_next_load: actual=%b/%h/%h/%0d required=1/%h/0032/4", gd, rd, ma, sc, ex); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_back_to_back();
      test_timeout();
      test_unaligned();
      test_rst_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
